// File: rtl/motor_pkg.sv
// Shared constants for the H-bridge PWM controller: wheel mode codes,
// per-side state encoding and bridge direction pin patterns.
package motor_pkg;

  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_FWD  = 2'd1;
  localparam logic [1:0] MODE_BWD  = 2'd2;
  localparam logic [1:0] MODE_OFF3 = 2'd3;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    DRIVE = 2'd1,
    DEAD  = 2'd2
  } side_state_e;

  localparam logic [1:0] IN_FWD   = 2'b10;
  localparam logic [1:0] IN_BWD   = 2'b01;
  localparam logic [1:0] IN_COAST = 2'b00;

  function automatic logic [1:0] dir_to_in(input logic bwd);
    return bwd ? IN_BWD : IN_FWD;
  endfunction

endpackage

// File: rtl/motor_side.sv
// One wheel: STOP/DRIVE/DEAD sequencing, soft-start duty ramp, reversal
// coast interval and the registered PWM comparator.
module motor_side #(
  parameter int PWM_BITS     = 10,
  parameter int RAMP_START   = 512,
  parameter int RAMP_STEP    = 64,
  parameter int DUTY_TARGET  = 1000,
  parameter int DEAD_PERIODS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          i_mode,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  input  logic                i_period_end,
  output logic                o_en,
  output logic [1:0]          o_in
);
  import motor_pkg::*;

  localparam int DEAD_W = $clog2(DEAD_PERIODS + 1);
  localparam logic [PWM_BITS-1:0] L_START  = PWM_BITS'(RAMP_START);
  localparam logic [PWM_BITS:0]   L_STEP   = (PWM_BITS + 1)'(RAMP_STEP);
  localparam logic [PWM_BITS:0]   L_TARGET = (PWM_BITS + 1)'(DUTY_TARGET);
  localparam logic [DEAD_W-1:0]   L_DEAD   = DEAD_W'(DEAD_PERIODS);

  side_state_e         r_state, w_state;
  logic                r_bwd, w_bwd;
  logic [PWM_BITS-1:0] r_duty, w_duty;
  logic [DEAD_W-1:0]   r_dead, w_dead;
  logic [1:0]          r_in, w_in;
  logic                r_en;
  logic                w_is_fwd, w_is_bwd;
  logic [PWM_BITS:0]   w_ramp;

  assign w_is_fwd = (i_mode == MODE_FWD);
  assign w_is_bwd = (i_mode == MODE_BWD);
  // Ramp sum is one bit wider so the saturation compare cannot wrap.
  assign w_ramp   = {1'b0, r_duty} + L_STEP;

  always_comb begin
    w_state = r_state;
    w_bwd   = r_bwd;
    w_duty  = r_duty;
    w_dead  = r_dead;
    w_in    = r_in;
    case (r_state)
      STOP: begin
        if (w_is_fwd || w_is_bwd) begin
          w_state = DRIVE;
          w_bwd   = w_is_bwd;
          w_duty  = L_START;
          w_in    = dir_to_in(w_is_bwd);
        end else begin
          w_duty = '0;
          w_in   = IN_COAST;
        end
      end
      DRIVE: begin
        if (!(w_is_fwd || w_is_bwd)) begin
          w_state = STOP;
          w_duty  = '0;
          w_in    = IN_COAST;
        end else if (w_is_bwd != r_bwd) begin
          w_state = DEAD;
          w_duty  = '0;
          w_in    = IN_COAST;
          w_dead  = L_DEAD;
        end else if (i_period_end) begin
          w_duty = (w_ramp > L_TARGET) ? L_TARGET[PWM_BITS-1:0] : w_ramp[PWM_BITS-1:0];
        end else begin
          w_in = dir_to_in(r_bwd);
        end
      end
      DEAD: begin
        // Release only on a period boundary after the counter has drained,
        // so the coast always spans DEAD_PERIODS whole periods.
        if (!(w_is_fwd || w_is_bwd)) begin
          w_state = STOP;
          w_duty  = '0;
          w_in    = IN_COAST;
        end else if (i_period_end && (r_dead == '0)) begin
          w_state = DRIVE;
          w_bwd   = w_is_bwd;
          w_duty  = L_START;
          w_in    = dir_to_in(w_is_bwd);
        end else if (i_period_end) begin
          w_dead = r_dead - DEAD_W'(1);
        end else begin
          w_in = IN_COAST;
        end
      end
      default: begin
        w_state = STOP;
        w_duty  = '0;
        w_dead  = '0;
        w_in    = IN_COAST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= STOP;
      r_bwd   <= 1'b0;
      r_duty  <= '0;
      r_dead  <= '0;
      r_in    <= IN_COAST;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_bwd   <= w_bwd;
      r_duty  <= w_duty;
      r_dead  <= w_dead;
      r_in    <= w_in;
      r_en    <= (i_pwm_cnt < r_duty);
    end
  end

  assign o_en = r_en;
  assign o_in = r_in;

endmodule

// File: rtl/motor_pwm_ctrl.sv
// Dual-wheel L298 driver: shared prescaler and PWM counter feeding two
// independent motor_side instances.
module motor_pwm_ctrl #(
  parameter int PRESCALE     = 10,
  parameter int PWM_BITS     = 10,
  parameter int RAMP_START   = 512,
  parameter int RAMP_STEP    = 64,
  parameter int DUTY_TARGET  = 1000,
  parameter int DEAD_PERIODS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] l_mode,
  input  logic [1:0] r_mode,
  output logic [1:0] pwm,
  output logic [1:0] l_IN,
  output logic [1:0] r_IN
);
  import motor_pkg::*;

  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0]  r_presc;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                w_tick, w_period_end, w_l_en, w_r_en;

  assign w_tick       = (r_presc == PRESC_MAX);
  assign w_period_end = w_tick && (r_pwm_cnt == '1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc   <= '0;
      r_pwm_cnt <= '0;
    end else if (w_tick) begin
      r_presc   <= '0;
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end else begin
      r_presc   <= r_presc + PRESC_W'(1);
      r_pwm_cnt <= r_pwm_cnt;
    end
  end

  motor_side #(
    .PWM_BITS(PWM_BITS), .RAMP_START(RAMP_START), .RAMP_STEP(RAMP_STEP),
    .DUTY_TARGET(DUTY_TARGET), .DEAD_PERIODS(DEAD_PERIODS)
  ) u_left (
    .clk(clk), .rst(rst), .i_mode(l_mode), .i_pwm_cnt(r_pwm_cnt),
    .i_period_end(w_period_end), .o_en(w_l_en), .o_in(l_IN)
  );

  motor_side #(
    .PWM_BITS(PWM_BITS), .RAMP_START(RAMP_START), .RAMP_STEP(RAMP_STEP),
    .DUTY_TARGET(DUTY_TARGET), .DEAD_PERIODS(DEAD_PERIODS)
  ) u_right (
    .clk(clk), .rst(rst), .i_mode(r_mode), .i_pwm_cnt(r_pwm_cnt),
    .i_period_end(w_period_end), .o_en(w_r_en), .o_in(r_IN)
  );

  assign pwm = {w_l_en, w_r_en};

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Directed + randomized bench for motor_pwm_ctrl against a behavioural model.
module tb_motor_pwm_ctrl;
  localparam int PER  = 16;
  localparam int RS   = 4;
  localparam int STEP = 4;
  localparam int TGT  = 12;
  localparam int DP   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] l_mode = 2'd0;
  logic [1:0] r_mode = 2'd0;
  logic [1:0] pwm, l_IN, r_IN;

  always #5 clk = ~clk;

  motor_pwm_ctrl #(
    .PRESCALE(1), .PWM_BITS(4), .RAMP_START(RS), .RAMP_STEP(STEP),
    .DUTY_TARGET(TGT), .DEAD_PERIODS(DP)
  ) dut (
    .clk(clk), .rst(rst), .l_mode(l_mode), .r_mode(r_mode),
    .pwm(pwm), .l_IN(l_IN), .r_IN(r_IN)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 driving, 2 coasting; duty derived from ramp count.
  int         m_cnt;
  int         ph[2];
  logic [1:0] m_dirin[2];
  int         ramps[2];
  int         seen[2];
  logic       m_en[2];

  function automatic int duty_of(int i);
    int d;
    if (ph[i] != 1) return 0;
    d = RS + STEP * ramps[i];
    return (d > TGT) ? TGT : d;
  endfunction

  function automatic logic [1:0] exp_in(int i);
    return (ph[i] == 1) ? m_dirin[i] : 2'b00;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; ramps[i] = 0; seen[i] = 0; m_en[i] = 1'b0; m_dirin[i] = 2'b00;
    end
  endtask

  task automatic model_edge();
    bit         pe;
    logic [1:0] md[2];
    logic [1:0] want;
    pe = (m_cnt == PER - 1);
    md[0] = l_mode;
    md[1] = r_mode;
    for (int i = 0; i < 2; i++) begin
      m_en[i] = (m_cnt < duty_of(i));
      want = (md[i] == 2'd1) ? 2'b10 : (md[i] == 2'd2) ? 2'b01 : 2'b00;
      case (ph[i])
        0: if (want != 2'b00) begin ph[i] = 1; m_dirin[i] = want; ramps[i] = 0; end
        1: begin
          if (want == 2'b00) ph[i] = 0;
          else if (want != m_dirin[i]) begin ph[i] = 2; seen[i] = 0; end
          else if (pe) ramps[i]++;
        end
        2: begin
          if (want == 2'b00) ph[i] = 0;
          else if (pe) begin
            seen[i]++;
            if (seen[i] > DP) begin ph[i] = 1; m_dirin[i] = want; ramps[i] = 0; end
          end
        end
        default: ph[i] = 0;
      endcase
    end
    m_cnt = (m_cnt + 1) % PER;
  endtask

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("l_IN", l_IN, exp_in(0));
    chk("r_IN", r_IN, exp_in(1));
    chk("pwm", pwm, {m_en[0], m_en[1]});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    #2 rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm, 2'b00);
    chk("rst_lIN", l_IN, 2'b00);
    chk("rst_rIN", r_IN, 2'b00);
    rst = 1'b1;

    // Left forward from STOP: ramp 4 -> 8 -> 12
    l_mode = 2'd1;
    run(60);
    // Reversal with coast interval
    l_mode = 2'd2;
    run(70);
    // Reverse again, then off mid-coast, then restart
    l_mode = 2'd1;
    run(20);
    l_mode = 2'd0;
    run(3);
    l_mode = 2'd1;
    run(10);
    // Mode 3 in DRIVE and from STOP
    l_mode = 2'd3;
    run(5);
    run(5);
    // Both sides, then reverse only the right
    l_mode = 2'd1;
    r_mode = 2'd2;
    run(60);
    r_mode = 2'd1;
    run(70);

    // Asynchronous reset mid-drive
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_pwm", pwm, 2'b00);
    chk("arst_lIN", l_IN, 2'b00);
    chk("arst_rIN", r_IN, 2'b00);
    model_reset();
    l_mode = 2'd0;
    r_mode = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run(20);

    // Random mode sequences
    for (int s = 0; s < 40; s++) begin
      l_mode = 2'($urandom_range(0, 3));
      r_mode = 2'($urandom_range(0, 3));
      run($urandom_range(1, 40));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
